keypad_scanner: RTL

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_scanner_pkg.sv | 29 ++
 rtl/kb_frame_classify.sv | 27 ++
 rtl/keypad_scanner.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/keypad_scanner_pkg.sv
// Shared definitions for the keypad scanner: FSM encoding, frame classes and
// the key-code layout {row_idx, col_idx} that downstream decoders rely on.
package keypad_scanner_pkg;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_PRESS_DEB   = 2'd1,
    ST_HELD        = 2'd2,
    ST_RELEASE_DEB = 2'd3
  } kb_state_e;

  typedef enum logic [1:0] {
    FR_NONE   = 2'd0,
    FR_SINGLE = 2'd1,
    FR_MULTI  = 2'd2
  } frame_class_e;

  localparam int KEY_ROW_LSB = 2;
  localparam int KEY_COL_LSB = 0;

  function automatic logic [3:0] make_key_code(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    code = '0;
    code[KEY_ROW_LSB +: 2] = row;
    code[KEY_COL_LSB +: 2] = col;
    return code;
  endfunction

endpackage

// File: rtl/kb_frame_classify.sv
// Classifies one 16-position scan frame as NONE, SINGLE (with its key code)
// or MULTI. Hit bit layout: hits[col*4 + row].
module kb_frame_classify
  import keypad_scanner_pkg::*;
(
  input  logic [15:0]  hits,
  output frame_class_e cls,
  output logic [3:0]   code
);

  logic [4:0] n_hits;

  always_comb begin
    n_hits = '0;
    code   = '0;
    for (int i = 0; i < 16; i++) begin
      if (hits[i]) begin
        n_hits = n_hits + 5'd1;
        code   = make_key_code(2'(i), 2'(i >> 2));
      end
    end
    if (n_hits == 5'd0)      cls = FR_NONE;
    else if (n_hits == 5'd1) cls = FR_SINGLE;
    else                     cls = FR_MULTI;
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column drive, row synchroniser, per-frame hit
// capture and a debounce FSM that accepts single-key presses and releases.
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int DEB_FRAMES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scan_tick,
  input  logic [3:0] keyboard_row,
  output logic [3:0] keyboard_col,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_held
);

  localparam logic [2:0] DEB_N = 3'(DEB_FRAMES);

  logic [3:0]   row_sync_p0, row_sync_p1;
  logic [1:0]   col_idx;
  logic [11:0]  hits_q;
  kb_state_e    state_q, state_d;
  logic [2:0]   deb_cnt_q, deb_cnt_d;
  logic [3:0]   cand_q, cand_d;
  logic [3:0]   key_code_q, key_code_d;
  logic         key_valid_q, key_valid_d;
  logic         key_held_q, key_held_d;

  logic         frame_end;
  logic [15:0]  frame_hits;
  frame_class_e frm_cls;
  logic [3:0]   frm_code;
  logic [2:0]   deb_inc;
  logic         deb_done;

  // Row synchroniser and column scan
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_sync_p0 <= '0;
      row_sync_p1 <= '0;
      col_idx     <= '0;
      hits_q      <= '0;
    end else begin
      row_sync_p0 <= keyboard_row;
      row_sync_p1 <= row_sync_p0;
      if (scan_tick) begin
        case (col_idx)
          2'd0:    hits_q[3:0]  <= ~row_sync_p1;
          2'd1:    hits_q[7:4]  <= ~row_sync_p1;
          2'd2:    hits_q[11:8] <= ~row_sync_p1;
          default: ;
        endcase
        col_idx <= col_idx + 2'd1;
      end
    end
  end

  assign keyboard_col = ~(4'b0001 << col_idx);

  // Column 3 is classified straight from the synchroniser on the closing tick
  assign frame_end  = scan_tick && (col_idx == 2'd3);
  assign frame_hits = {~row_sync_p1, hits_q};

  kb_frame_classify u_classify (
    .hits (frame_hits),
    .cls  (frm_cls),
    .code (frm_code)
  );

  assign deb_inc  = deb_cnt_q + 3'd1;
  assign deb_done = (deb_inc == DEB_N);

  // Debounce FSM; MULTI frames leave every piece of state untouched
  always_comb begin
    state_d     = state_q;
    deb_cnt_d   = deb_cnt_q;
    cand_d      = cand_q;
    key_code_d  = key_code_q;
    key_held_d  = key_held_q;
    key_valid_d = 1'b0;
    if (frame_end && frm_cls != FR_MULTI) begin
      unique case (state_q)
        ST_IDLE: begin
          if (frm_cls == FR_SINGLE) begin
            cand_d    = frm_code;
            deb_cnt_d = 3'd1;
            if (DEB_N == 3'd1) begin
              state_d     = ST_HELD;
              deb_cnt_d   = '0;
              key_code_d  = frm_code;
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
            end else begin
              state_d = ST_PRESS_DEB;
            end
          end
        end
        ST_PRESS_DEB: begin
          if (frm_cls == FR_NONE) begin
            state_d   = ST_IDLE;
            deb_cnt_d = '0;
          end else if (frm_code != cand_q) begin
            cand_d    = frm_code;
            deb_cnt_d = 3'd1;
          end else if (deb_done) begin
            state_d     = ST_HELD;
            deb_cnt_d   = '0;
            key_code_d  = cand_q;
            key_valid_d = 1'b1;
            key_held_d  = 1'b1;
          end else begin
            deb_cnt_d = deb_inc;
          end
        end
        ST_HELD: begin
          if (frm_cls == FR_NONE) begin
            if (DEB_N == 3'd1) begin
              state_d    = ST_IDLE;
              deb_cnt_d  = '0;
              key_held_d = 1'b0;
            end else begin
              state_d   = ST_RELEASE_DEB;
              deb_cnt_d = 3'd1;
            end
          end
        end
        ST_RELEASE_DEB: begin
          if (frm_cls == FR_NONE) begin
            if (deb_done) begin
              state_d    = ST_IDLE;
              deb_cnt_d  = '0;
              key_held_d = 1'b0;
            end else begin
              deb_cnt_d = deb_inc;
            end
          end else begin
            state_d   = ST_HELD;
            deb_cnt_d = '0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      deb_cnt_q   <= '0;
      cand_q      <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      deb_cnt_q   <= deb_cnt_d;
      cand_q      <= cand_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign key_held  = key_held_q;

endmodule
